// File: rtl/inst_fetch_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | inst_fetch_ctrl_pkg : shared types/constants for the fetch controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package inst_fetch_ctrl_pkg;

  localparam int INST_WIDTH = 32;

  localparam logic ROM_ENABLE  = 1'b1;
  localparam logic ROM_DISABLE = 1'b0;
  localparam logic [INST_WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HOLD   = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Sequential fetch step; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_ctrl_fetch_buf.sv
// +----------------------------------------------------------------------+
// | inst_fetch_ctrl_fetch_buf : 2-entry {pc, inst} FIFO, flush over push  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module inst_fetch_ctrl_fetch_buf
  import inst_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wr_entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         full_o
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i && (count_q != 2'd0)) begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      // Write slot is chosen after the pop so a same-cycle pop+push stays ordered.
      if (push_i && (count_d != 2'd2)) begin
        if (count_d == 2'd0) begin
          e0_d = wr_entry_i;
        end else begin
          e1_d = wr_entry_i;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = (count_q != 2'd0) ? e0_q : '0;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | inst_fetch_ctrl : PC/ROM sequencer with 2-entry fetch buffer          |
// | Optional perf counters: FETCH_PERF_CNT_EN             Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rom_ce,
  output logic [31:0]           rom_addr,
  input  logic [INST_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         pop;
  logic         fetch;
  logic         buf_full;
  logic [1:0]   buf_count;
  logic [1:0]   count_next;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign inst_valid = (buf_count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  // Fetch only if the slot freed by this cycle's pop (or an empty slot) exists.
  assign fetch      = ((state_q == FS_FETCH) || (state_q == FS_HOLD)) && !halt
                      && (!buf_full || pop);
  assign count_next = buf_count + {1'b0, fetch} - {1'b0, pop};

  assign rom_ce   = fetch ? ROM_ENABLE : ROM_DISABLE;
  assign rom_addr = pc_q;
  assign wr_entry = '{pc: pc_q, inst: rom_data};

  inst_fetch_ctrl_fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fetch),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (buf_count),
    .full_o     (buf_full)
  );

  assign inst    = inst_valid ? head.inst : ZERO_WORD;
  assign inst_pc = head.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = halt ? FS_HALTED : FS_FETCH;
    end else begin
      if (fetch) begin
        pc_d = pc_inc(pc_q);
      end
      unique case (state_q)
        FS_BOOT, FS_HALTED: state_d = halt ? FS_HALTED : FS_FETCH;
        FS_FETCH, FS_HOLD:  state_d = halt ? FS_HALTED :
                                      ((count_next == 2'd2) ? FS_HOLD : FS_FETCH);
        default:            state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;
  logic [1:0]  discard_cnt;

  // The entry popped alongside a redirect was consumed, not discarded.
  assign discard_cnt = buf_count - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (fetch) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (redirect_valid) begin
        perf_flush_q <= perf_flush_q + {30'd0, discard_cnt};
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_inst_fetch_ctrl : directed self-checking bench for inst_fetch_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_ready;

  logic        rom_ce0, rom_ce1;
  logic [31:0] rom_addr0, rom_addr1;
  logic [31:0] rom_data0, rom_data1;
  logic        inst_valid0, inst_valid1;
  logic [31:0] inst0, inst1;
  logic [31:0] inst_pc0, inst_pc1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch0, perf_flush0, perf_fetch1, perf_flush1;
`endif

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    case (idx)
      10'd0:   return 32'h0c00_0002;
      10'd1:   return 32'h0022_1820;
      10'd2:   return 32'h0041_1822;
      default: return 32'hC0DE_0000 | {20'h0, a[11:0]};
    endcase
  endfunction

  assign rom_data0 = rom_word(rom_addr0);
  assign rom_data1 = rom_word(rom_addr1);

  inst_fetch_ctrl dut0 (
    .clk            (clk),
    .rst            (rst),
    .rom_ce         (rom_ce0),
    .rom_addr       (rom_addr0),
    .rom_data       (rom_data0),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid0),
    .inst_ready     (inst_ready),
    .inst           (inst0),
    .inst_pc        (inst_pc0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch0),
    .perf_flush_cnt (perf_flush0)
`endif
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .rom_ce         (rom_ce1),
    .rom_addr       (rom_addr1),
    .rom_data       (rom_data1),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .halt           (1'b0),
    .inst_valid     (inst_valid1),
    .inst_ready     (1'b1),
    .inst           (inst1),
    .inst_pc        (inst_pc1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch1),
    .perf_flush_cnt (perf_flush1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"},    {31'd0, rom_ce0},     32'd0);
    chk({tag, "_addr"},  rom_addr0,            32'h0);
    chk({tag, "_valid"}, {31'd0, inst_valid0}, 32'd0);
    chk({tag, "_inst"},  inst0,                32'h0);
    chk({tag, "_pc"},    inst_pc0,             32'h0);
    chk({tag, "_addr1"}, rom_addr1,            32'hFFFF_FFFC);
    chk({tag, "_ce1"},   {31'd0, rom_ce1},     32'd0);
  endtask

  initial begin
    rst = 1'b1; inst_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc();
    chk_reset("rst");

    // Streaming start-up with decode always ready
    rst = 1'b0; #1;
    chk("boot_ce", {31'd0, rom_ce0}, 32'd0);
    cyc();
    chk("b_ce", {31'd0, rom_ce0}, 32'd1);
    chk("b_addr", rom_addr0, 32'h0);
    chk("b_valid", {31'd0, inst_valid0}, 32'd0);
    chk("b_addr1", rom_addr1, 32'hFFFF_FFFC);
    cyc();
    chk("s0_inst", inst0, 32'h0c00_0002);
    chk("s0_pc", inst_pc0, 32'h0);
    chk("wrap_pc1", inst_pc1, 32'hFFFF_FFFC);
    chk("wrap_addr1", rom_addr1, 32'h0);
    cyc();
    chk("s1_inst", inst0, 32'h0022_1820);
    chk("s1_pc", inst_pc0, 32'h4);
    chk("wrap_inst1", inst1, 32'h0c00_0002);
    chk("wrap_ipc1", inst_pc1, 32'h0);
    cyc();
    chk("s2_inst", inst0, 32'h0041_1822);
    chk("s2_pc", inst_pc0, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch0, 32'd3);
`endif

    // Back-pressure from the start
    rst = 1'b1; inst_ready = 1'b0; cyc();
    rst = 1'b0; #1;
    cyc();
    cyc();
    chk("bp_addr4", rom_addr0, 32'h4);
    cyc();
    chk("hold_ce", {31'd0, rom_ce0}, 32'd0);
    chk("hold_addr", rom_addr0, 32'h8);
    chk("hold_pc", inst_pc0, 32'h0);
    chk("hold_valid", {31'd0, inst_valid0}, 32'd1);
    cyc(); cyc();
    chk("hold2_pc", inst_pc0, 32'h0);
    chk("hold2_inst", inst0, 32'h0c00_0002);
    chk("hold2_ce", {31'd0, rom_ce0}, 32'd0);
    inst_ready = 1'b1; #1;
    chk("resume_ce", {31'd0, rom_ce0}, 32'd1);
    chk("resume_addr", rom_addr0, 32'h8);
    chk("resume_pc", inst_pc0, 32'h0);
    cyc();
    chk("r1_pc", inst_pc0, 32'h4);
    chk("r1_addr", rom_addr0, 32'hC);

    // Redirect while buffer holds 0x8, 0xC
    cyc();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
    chk("rd_head", inst_pc0, 32'h8);
    chk("rd_ce", {31'd0, rom_ce0}, 32'd0);
    cyc();
    redirect_valid = 1'b0; inst_ready = 1'b1; #1;
    chk("rd_valid", {31'd0, inst_valid0}, 32'd0);
    chk("rd_addr", rom_addr0, 32'h20);
    chk("rd_ce2", {31'd0, rom_ce0}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flush2", perf_flush0, 32'd2);
`endif
    cyc();
    chk("rd_tpc", inst_pc0, 32'h20);
    chk("rd_tinst", inst0, 32'hC0DE_0020);

    // Redirect coinciding with a pop, unaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h23; #1;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("rp_valid", {31'd0, inst_valid0}, 32'd0);
    chk("rp_addr", rom_addr0, 32'h20);
    cyc();
    chk("rp_pc", inst_pc0, 32'h20);
    chk("rp_valid2", {31'd0, inst_valid0}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flush_pop", perf_flush0, 32'd2);
`endif
    cyc();
    chk("rp_next", inst_pc0, 32'h24);

    // Halt for five cycles while the buffer drains
    halt = 1'b1; inst_ready = 1'b0; #1;
    chk("h_ce0", {31'd0, rom_ce0}, 32'd0);
    cyc();
    chk("h_ce1", {31'd0, rom_ce0}, 32'd0);
    chk("h_head", inst_pc0, 32'h24);
    chk("h_addr", rom_addr0, 32'h28);
    inst_ready = 1'b1; #1;
    cyc();
    chk("h_drained", {31'd0, inst_valid0}, 32'd0);
    chk("h_ce2", {31'd0, rom_ce0}, 32'd0);
    cyc(); cyc();
    chk("h_ce4", {31'd0, rom_ce0}, 32'd0);
    chk("h_addr4", rom_addr0, 32'h28);
    cyc();
    halt = 1'b0; #1;
    chk("h_rel_ce", {31'd0, rom_ce0}, 32'd0);
    cyc();
    chk("h_res_ce", {31'd0, rom_ce0}, 32'd1);
    chk("h_res_addr", rom_addr0, 32'h28);
    cyc();
    chk("h_res_pc", inst_pc0, 32'h28);
    chk("h_res_inst", inst0, 32'hC0DE_0028);

    // Asynchronous reset mid-stream
    #2; rst = 1'b1; #1;
    chk_reset("arst");
    #5; rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
